alu_arbiter: RTL and testbench

- Shares one combinational ALU (4-bit opcode, 32-bit signed operands) between NUM_REQ requesters, e.g. execute stage and address-generation/branch-compare logic.
- Round-robin arbitration with valid/ready handshakes on request and response.
- Two-stage pipeline: issue register drives the ALU ports; response register captures the ALU result.
- Sits between requesters and the ALU instance in the core datapath.

---
 rtl/alu_arbiter_pkg.sv | 24 ++
 rtl/alu_arbiter_rr_arbiter.sv | 38 +++
 rtl/alu_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcode encodings and default widths.
package alu_arbiter_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned OPW_DEF  = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module rr_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDXW = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [IDXW-1:0]    ptr_in,
    output logic [NUM_REQ-1:0] gnt_out,
    output logic [IDXW-1:0]    gnt_idx_out,
    output logic               gnt_valid_out
);

    logic              found;
    logic [IDXW-1:0]   idx;
    int unsigned       idx_full;

    always_comb begin
        gnt_out       = '0;
        gnt_idx_out   = '0;
        gnt_valid_out = 1'b0;
        found         = 1'b0;
        idx           = '0;
        idx_full      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx_full = (32'(ptr_in) + k) % NUM_REQ;
            idx      = IDXW'(idx_full);
            if (!found && req_in[idx]) begin
                found         = 1'b1;
                gnt_out[idx]  = 1'b1;
                gnt_idx_out   = idx;
                gnt_valid_out = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters through an issue register
// and a response register, with round-robin arbitration and valid/ready handshakes.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned OPW     = OPW_DEF
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    flush_in,
    input  logic [NUM_REQ-1:0]      req_valid_in,
    output logic [NUM_REQ-1:0]      req_ready_out,
    input  logic [NUM_REQ*XLEN-1:0] req_op_1_in,
    input  logic [NUM_REQ*XLEN-1:0] req_op_2_in,
    input  logic [NUM_REQ*OPW-1:0]  req_opcode_in,
    output logic [XLEN-1:0]         alu_op_1_out,
    output logic [XLEN-1:0]         alu_op_2_out,
    output logic [OPW-1:0]          alu_opcode_out,
    input  logic [XLEN-1:0]         alu_result_in,
    output logic [NUM_REQ-1:0]      rsp_valid_out,
    output logic [XLEN-1:0]         rsp_data_out,
    input  logic [NUM_REQ-1:0]      rsp_ready_in
);

    localparam int unsigned IDXW = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0] grant_vec;
    logic [IDXW-1:0]    grant_idx;
    logic               grant_valid;

    logic               issue_valid_q, issue_valid_d;
    logic [IDXW-1:0]    issue_owner_q, issue_owner_d;
    logic [XLEN-1:0]    alu_op_1_q, alu_op_1_d;
    logic [XLEN-1:0]    alu_op_2_q, alu_op_2_d;
    logic [OPW-1:0]     alu_opcode_q, alu_opcode_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDXW-1:0]    rsp_owner_q, rsp_owner_d;
    logic [XLEN-1:0]    rsp_data_q, rsp_data_d;
    logic [IDXW-1:0]    rr_ptr_q, rr_ptr_d;

    logic drain, rsp_free, issue_free, accept, capture;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_in        (req_valid_in),
        .ptr_in        (rr_ptr_q),
        .gnt_out       (grant_vec),
        .gnt_idx_out   (grant_idx),
        .gnt_valid_out (grant_valid)
    );

    always_comb begin
        drain      = rsp_valid_q & rsp_ready_in[rsp_owner_q];
        rsp_free   = !rsp_valid_q | drain;
        issue_free = !issue_valid_q | rsp_free;
        // Gated by reset so no requester sees a grant while the pipeline is held in reset.
        accept     = rst_n_in & grant_valid & issue_free & !flush_in;
        capture    = issue_valid_q & rsp_free & !flush_in;

        issue_valid_d = issue_valid_q;
        issue_owner_d = issue_owner_q;
        alu_op_1_d    = alu_op_1_q;
        alu_op_2_d    = alu_op_2_q;
        alu_opcode_d  = alu_opcode_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_owner_d   = rsp_owner_q;
        rsp_data_d    = rsp_data_q;
        rr_ptr_d      = rr_ptr_q;

        if (flush_in) begin
            issue_valid_d = 1'b0;
            rsp_valid_d   = 1'b0;
        end else begin
            if (capture) begin
                rsp_valid_d   = 1'b1;
                rsp_owner_d   = issue_owner_q;
                rsp_data_d    = alu_result_in;
                issue_valid_d = 1'b0;
            end else if (drain) begin
                rsp_valid_d = 1'b0;
            end
            if (accept) begin
                issue_valid_d = 1'b1;
                issue_owner_d = grant_idx;
                alu_op_1_d    = req_op_1_in[grant_idx*XLEN +: XLEN];
                alu_op_2_d    = req_op_2_in[grant_idx*XLEN +: XLEN];
                alu_opcode_d  = req_opcode_in[grant_idx*OPW +: OPW];
                rr_ptr_d      = (grant_idx == IDXW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            issue_valid_q <= 1'b0;
            issue_owner_q <= '0;
            alu_op_1_q    <= '0;
            alu_op_2_q    <= '0;
            alu_opcode_q  <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_owner_q   <= '0;
            rsp_data_q    <= '0;
            rr_ptr_q      <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_owner_q <= issue_owner_d;
            alu_op_1_q    <= alu_op_1_d;
            alu_op_2_q    <= alu_op_2_d;
            alu_opcode_q  <= alu_opcode_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_owner_q   <= rsp_owner_d;
            rsp_data_q    <= rsp_data_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    always_comb begin
        req_ready_out  = accept ? grant_vec : '0;
        alu_op_1_out   = alu_op_1_q;
        alu_op_2_out   = alu_op_2_q;
        alu_opcode_out = alu_opcode_q;
        rsp_valid_out  = rsp_valid_q ? (NUM_REQ'(1) << rsp_owner_q) : '0;
        rsp_data_out   = rsp_data_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of in-flight operations.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int XL = 32;
    localparam int OW = 4;

    logic            clk_in = 1'b0;
    logic            rst_n_in;
    logic            flush_in;
    logic [N-1:0]    req_valid_in, req_ready_out, rsp_valid_out, rsp_ready_in;
    logic [N*XL-1:0] req_op_1_in, req_op_2_in;
    logic [N*OW-1:0] req_opcode_in;
    logic [XL-1:0]   alu_op_1_out, alu_op_2_out, alu_result_in, rsp_data_out;
    logic [OW-1:0]   alu_opcode_out;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] alu_ref(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (opc)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0111: return a & b;
            4'b0110: return a | b;
            4'b0100: return a ^ b;
            4'b0001: return a << sh;
            4'b0101: return a >> sh;
            4'b1101: return $signed(a) >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result_in = alu_ref(alu_opcode_out, alu_op_1_out, alu_op_2_out);

    alu_arbiter #(.NUM_REQ(N), .XLEN(XL), .OPW(OW)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .flush_in       (flush_in),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_op_1_in    (req_op_1_in),
        .req_op_2_in    (req_op_2_in),
        .req_opcode_in  (req_opcode_in),
        .alu_op_1_out   (alu_op_1_out),
        .alu_op_2_out   (alu_op_2_out),
        .alu_opcode_out (alu_opcode_out),
        .alu_result_in  (alu_result_in),
        .rsp_valid_out  (rsp_valid_out),
        .rsp_data_out   (rsp_data_out),
        .rsp_ready_in   (rsp_ready_in)
    );

    // Model: ordered list of in-flight ops; the head sits in the response slot when head_done.
    typedef struct {
        int          owner;
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  opc;
    } op_t;

    op_t         fl[$];
    bit          head_done;
    int          rr;
    logic [31:0] m_alu_a, m_alu_b, m_rsp;
    logic [3:0]  m_alu_opc;

    function automatic int m_winner();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (rr + k) % N;
            if (req_valid_in[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit m_free();
        return (fl.size() < 2) || (rsp_ready_in[fl[0].owner] == 1'b1);
    endfunction

    function automatic logic [N-1:0] m_ready();
        int w;
        w = m_winner();
        if (!rst_n_in || flush_in || w < 0 || !m_free()) return '0;
        return N'(1) << w;
    endfunction

    function automatic logic [N-1:0] m_rsp_valid();
        if (!head_done) return '0;
        return N'(1) << fl[0].owner;
    endfunction

    task automatic model_reset();
        fl.delete();
        head_done = 1'b0;
        rr        = 0;
        m_alu_a   = '0;
        m_alu_b   = '0;
        m_alu_opc = '0;
        m_rsp     = '0;
    endtask

    task automatic tick();
        int  w;
        bit  acc, drn, fl_now;
        op_t nop;
        w      = m_winner();
        acc    = (m_ready() != '0);
        drn    = head_done && (rsp_ready_in[fl[0].owner] == 1'b1);
        fl_now = flush_in;
        if (acc) begin
            nop.owner = w;
            nop.a     = req_op_1_in[w*XL +: XL];
            nop.b     = req_op_2_in[w*XL +: XL];
            nop.opc   = req_opcode_in[w*OW +: OW];
            nop.res   = alu_ref(nop.opc, nop.a, nop.b);
        end
        @(posedge clk_in);
        #1;
        if (fl_now) begin
            fl.delete();
            head_done = 1'b0;
        end else begin
            if (drn) begin
                void'(fl.pop_front());
                head_done = 1'b0;
            end
            if (!head_done && fl.size() > 0) begin
                head_done = 1'b1;
                m_rsp     = fl[0].res;
            end
            if (acc) begin
                fl.push_back(nop);
                rr        = (w + 1) % N;
                m_alu_a   = nop.a;
                m_alu_b   = nop.b;
                m_alu_opc = nop.opc;
            end
        end
    endtask

    task automatic set_req(input int i, input bit v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] o);
        req_valid_in[i]           = v;
        req_op_1_in[i*XL +: XL]   = a;
        req_op_2_in[i*XL +: XL]   = b;
        req_opcode_in[i*OW +: OW] = o;
    endtask

    task automatic test_reset();
        rst_n_in      = 1'b0;
        flush_in      = 1'b0;
        req_valid_in  = '1;
        req_op_1_in   = '1;
        req_op_2_in   = '1;
        req_opcode_in = '0;
        rsp_ready_in  = '1;
        model_reset();
        #12;
        total++; if (req_ready_out !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", req_ready_out); end
        total++; if (rsp_valid_out !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b want=00", rsp_valid_out); end
        total++; if (rsp_data_out !== 32'd0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data_out); end
        total++; if ({alu_op_1_out, alu_op_2_out, alu_opcode_out} !== '0) begin bad++; $display("FAIL reset_alu got=%h/%h/%h want=0", alu_op_1_out, alu_op_2_out, alu_opcode_out); end
        req_valid_in = '0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_single();
        rsp_ready_in = 2'b11;
        set_req(0, 1'b1, 32'd5, 32'd7, ALU_ADD);
        set_req(1, 1'b0, 32'd0, 32'd0, ALU_ADD);
        #1;
        total++; if (req_ready_out !== 2'b01) begin bad++; $display("FAIL single_ready got=%b want=01", req_ready_out); end
        tick();
        req_valid_in = '0;
        #1;
        total++; if (alu_opcode_out !== 4'b0000 || alu_op_1_out !== 32'd5 || alu_op_2_out !== 32'd7) begin bad++; $display("FAIL single_issue got=%h/%h/%h want=0/5/7", alu_opcode_out, alu_op_1_out, alu_op_2_out); end
        total++; if (rsp_valid_out !== 2'b00) begin bad++; $display("FAIL single_early_rsp got=%b want=00", rsp_valid_out); end
        tick();
        #1;
        total++; if (rsp_valid_out !== 2'b01 || rsp_data_out !== 32'd12) begin bad++; $display("FAIL single_rsp got=%b/%0d want=01/12", rsp_valid_out, rsp_data_out); end
        tick();
        #1;
        total++; if (rsp_valid_out !== 2'b00) begin bad++; $display("FAIL single_drained got=%b want=00", rsp_valid_out); end
    endtask

    task automatic test_contention();
        logic [N-1:0] prev;
        prev = '0;
        rsp_ready_in = 2'b11;
        set_req(0, 1'b1, 32'd10, 32'd3, ALU_SUB);
        set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, ALU_SLTU);
        for (int c = 0; c < 8; c++) begin
            #1;
            total++; if (req_ready_out !== m_ready()) begin bad++; $display("FAIL cont_ready c=%0d got=%b want=%b", c, req_ready_out, m_ready()); end
            if (c > 0) begin
                total++; if (req_ready_out !== ~prev) begin bad++; $display("FAIL cont_alternate c=%0d got=%b want=%b", c, req_ready_out, ~prev); end
            end
            if (c >= 2) begin
                total++; if (rsp_valid_out !== m_rsp_valid() || rsp_valid_out === 2'b00) begin bad++; $display("FAIL cont_rsp_valid c=%0d got=%b want=%b", c, rsp_valid_out, m_rsp_valid()); end
                total++; if (rsp_data_out !== (rsp_valid_out[0] ? 32'd7 : 32'd0)) begin bad++; $display("FAIL cont_rsp_data c=%0d got=%0d", c, rsp_data_out); end
            end
            prev = req_ready_out;
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] h_a, h_b;
        logic [3:0]  h_o;
        int          seen;
        rsp_ready_in = 2'b00;
        set_req(0, 1'b1, 32'd100, 32'd1, ALU_ADD);
        set_req(1, 1'b1, 32'h8000_0000, 32'd4, ALU_SRA);
        tick();
        tick();
        h_a = m_alu_a;
        h_b = m_alu_b;
        h_o = m_alu_opc;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (req_ready_out !== 2'b00) begin bad++; $display("FAIL bp_ready c=%0d got=%b want=00", c, req_ready_out); end
            total++; if (alu_op_1_out !== h_a || alu_op_2_out !== h_b || alu_opcode_out !== h_o) begin bad++; $display("FAIL bp_alu_stable c=%0d got=%h/%h/%h want=%h/%h/%h", c, alu_op_1_out, alu_op_2_out, alu_opcode_out, h_a, h_b, h_o); end
            tick();
        end
        req_valid_in = '0;
        rsp_ready_in = 2'b11;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++; if (rsp_valid_out !== m_rsp_valid() || rsp_data_out !== m_rsp) begin bad++; $display("FAIL bp_release c=%0d got=%b/%h want=%b/%h", c, rsp_valid_out, rsp_data_out, m_rsp_valid(), m_rsp); end
            if (rsp_valid_out != 0) seen++;
            tick();
        end
        total++; if (seen !== 2) begin bad++; $display("FAIL bp_count got=%0d want=2", seen); end
    endtask

    task automatic test_drain_capture();
        rsp_ready_in = 2'b00;
        set_req(0, 1'b1, 32'd1, 32'd2, ALU_ADD);
        set_req(1, 1'b0, 32'd0, 32'd0, ALU_ADD);
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD);
        set_req(1, 1'b1, 32'd6, 32'd3, ALU_XOR);
        tick();
        req_valid_in = '0;
        tick();
        #1;
        total++; if (rsp_valid_out !== 2'b01 || rsp_data_out !== 32'd3) begin bad++; $display("FAIL dc_held got=%b/%0d want=01/3", rsp_valid_out, rsp_data_out); end
        rsp_ready_in = 2'b11;
        tick();
        #1;
        total++; if (rsp_valid_out !== 2'b10 || rsp_data_out !== 32'd5) begin bad++; $display("FAIL dc_no_gap got=%b/%0d want=10/5", rsp_valid_out, rsp_data_out); end
        total++; if (rsp_valid_out !== m_rsp_valid() || rsp_data_out !== m_rsp) begin bad++; $display("FAIL dc_model got=%b/%h want=%b/%h", rsp_valid_out, rsp_data_out, m_rsp_valid(), m_rsp); end
        tick();
    endtask

    task automatic test_flush();
        int rr_before;
        rsp_ready_in = 2'b00;
        set_req(0, 1'b1, 32'hF0F0, 32'h0FF0, ALU_AND);
        set_req(1, 1'b0, 32'd0, 32'd0, ALU_ADD);
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD);
        set_req(1, 1'b1, 32'h00F0, 32'h0F00, ALU_OR);
        tick();
        req_valid_in = 2'b11;
        flush_in     = 1'b1;
        rr_before    = rr;
        #1;
        total++; if (req_ready_out !== 2'b00) begin bad++; $display("FAIL flush_ready got=%b want=00", req_ready_out); end
        total++; if (rsp_valid_out !== 2'b01) begin bad++; $display("FAIL flush_pre_rsp got=%b want=01", rsp_valid_out); end
        tick();
        flush_in = 1'b0;
        #1;
        total++; if (rsp_valid_out !== 2'b00) begin bad++; $display("FAIL flush_rsp got=%b want=00", rsp_valid_out); end
        total++; if (req_ready_out !== (N'(1) << rr_before)) begin bad++; $display("FAIL flush_rr got=%b want=%b", req_ready_out, N'(1) << rr_before); end
        req_valid_in = '0;
        tick();
        tick();
        #1;
        total++; if (rsp_valid_out !== 2'b00) begin bad++; $display("FAIL flush_no_ghost got=%b want=00", rsp_valid_out); end
    endtask

    task automatic test_async_reset();
        rsp_ready_in = 2'b11;
        set_req(0, 1'b1, 32'd9, 32'd4, ALU_SUB);
        set_req(1, 1'b1, 32'd3, 32'd2, ALU_SLL);
        for (int c = 0; c < 3; c++) tick();
        #3;
        rst_n_in = 1'b0;
        model_reset();
        #1;
        total++; if (req_ready_out !== 2'b00 || rsp_valid_out !== 2'b00) begin bad++; $display("FAIL areset_ctl got=%b/%b want=00/00", req_ready_out, rsp_valid_out); end
        total++; if ({rsp_data_out, alu_op_1_out, alu_op_2_out, alu_opcode_out} !== '0) begin bad++; $display("FAIL areset_data got=%h/%h/%h/%h want=0", rsp_data_out, alu_op_1_out, alu_op_2_out, alu_opcode_out); end
        @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;
        total++; if (req_ready_out !== 2'b01) begin bad++; $display("FAIL areset_first_grant got=%b want=01", req_ready_out); end
        req_valid_in = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            total++; if (rsp_valid_out !== 2'b00) begin bad++; $display("FAIL areset_stale c=%0d got=%b want=00", c, rsp_valid_out); end
        end
    endtask

    task automatic test_random();
        logic [3:0] opc_tab [11];
        opc_tab = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111, 4'b0110,
                    4'b0100, 4'b0001, 4'b0101, 4'b1101, 4'b1111};
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, opc_tab[$urandom_range(0, 10)]);
            rsp_ready_in = N'($urandom);
            flush_in     = ($urandom_range(0, 19) == 0);
            #1;
            total++; if (req_ready_out !== m_ready()) begin bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, req_ready_out, m_ready()); end
            total++; if (rsp_valid_out !== m_rsp_valid()) begin bad++; $display("FAIL rnd_rsp_valid c=%0d got=%b want=%b", c, rsp_valid_out, m_rsp_valid()); end
            total++; if (rsp_data_out !== m_rsp) begin bad++; $display("FAIL rnd_rsp_data c=%0d got=%h want=%h", c, rsp_data_out, m_rsp); end
            total++; if (alu_op_1_out !== m_alu_a || alu_op_2_out !== m_alu_b || alu_opcode_out !== m_alu_opc) begin bad++; $display("FAIL rnd_alu c=%0d got=%h/%h/%h want=%h/%h/%h", c, alu_op_1_out, alu_op_2_out, alu_opcode_out, m_alu_a, m_alu_b, m_alu_opc); end
            tick();
        end
        flush_in     = 1'b0;
        req_valid_in = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_drain_capture();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
